// File: rtl/tessera_ram_wbp_if.sv
// Wishbone slave bus bundle for tessera_ram_wbp: master drives request fields,
// slave returns read data and the ack/err terminations.
interface tessera_ram_wbp_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_i;
  logic        wb_cab_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cab_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cab_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/tessera_ram_wbp.sv
// Wishbone on-chip RAM: first beat acked WAIT+1 cycles after strobe, cab bursts one beat/cycle;
// master stalls simply by holding the request, dropping cyc/stb abandons the transfer.
module tessera_ram_wbp #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int          WAIT     = 0,
  parameter bit          BURST_EN = 1'b1,
  parameter bit          ERR_EN   = 1'b1
) (
  input logic             sys_wb_clk,
  input logic             sys_wb_res,
  tessera_ram_wbp_if.slave wb
);
  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_BURST, S_ERR} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [IW-1:0]    idx;
  logic             ack_q;
  logic             err_q;
  logic [31:0]      rd_q;
  logic [3:0][7:0]  mem [DEPTH];

  logic          active;
  logic          hit;
  logic [IW-1:0] adr_idx;
  logic          beat;
  logic          burst_go;
  logic          wr_go;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic          read_ack;
  logic          unused_adr_bits;

  assign active          = wb.wb_cyc_i & wb.wb_stb_i;
  assign hit             = (wb.wb_adr_i[31:ADDR_W] == BASE[31:ADDR_W]);
  assign adr_idx         = wb.wb_adr_i[ADDR_W-1:2];
  assign unused_adr_bits = ^wb.wb_adr_i[1:0];

  // A burst beat is only taken when the master's address matches our prediction.
  assign beat     = (state == S_BURST) && active && wb.wb_cab_i && hit && (adr_idx == idx);
  assign burst_go = BURST_EN && (state == S_ACK) && active && wb.wb_cab_i;
  assign wr_go    = wb.wb_we_i && (((state == S_ACK) && active) || beat);

  // The array is read one edge ahead so the word is waiting in rd_q when ack rises.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = idx;
    case (state)
      S_IDLE: begin
        if (active && hit && (WAIT == 0)) begin
          rd_en  = 1'b1;
          rd_idx = adr_idx;
        end
      end
      S_WAIT:  rd_en = active && (cnt == 4'd1);
      S_ACK: begin
        rd_en  = burst_go;
        rd_idx = idx + 1'b1;
      end
      S_BURST: begin
        rd_en  = beat;
        rd_idx = idx + 1'b1;
      end
      default: rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge sys_wb_clk) begin
    if (wr_go) begin
      for (int i = 0; i < 4; i++) begin
        if (wb.wb_sel_i[i]) mem[idx][i] <= wb.wb_dat_i[8*i +: 8];
      end
    end
    if (rd_en) rd_q <= mem[rd_idx];
  end

  always_ff @(posedge sys_wb_clk or posedge sys_wb_res) begin
    if (sys_wb_res) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      idx   <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (active) begin
            if (hit) begin
              cnt <= 4'(WAIT);
              idx <= adr_idx;
              if (WAIT == 0) begin
                state <= S_ACK;
                ack_q <= 1'b1;
              end else begin
                state <= S_WAIT;
              end
            end else begin
              state <= S_ERR;
              if (ERR_EN) err_q <= 1'b1;
              else        ack_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!active) begin
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= S_ACK;
            ack_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ACK: begin
          if (burst_go) begin
            state <= S_BURST;
            idx   <= idx + 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BURST: begin
          if (beat) idx   <= idx + 1'b1;
          else      state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Out-of-window responses carry ack_q/err_q but never read data.
  assign read_ack    = active && !wb.wb_we_i && ((state == S_ACK) || beat);
  assign wb.wb_ack_o = active && (ack_q || beat);
  assign wb.wb_err_o = active && err_q;

  always_comb begin
    wb.wb_dat_o = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (read_ack && wb.wb_sel_i[i]) wb.wb_dat_o[8*i +: 8] = rd_q[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_tessera_ram_wbp.sv
// Bench for tessera_ram_wbp: three configurations share one stimulus driver, each
// checked against a per-instance word array model of the RAM and its response rules.
module tb_tessera_ram_wbp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, cab = 1'b0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic [3:0]  sel = 4'h0;
  int          tgt = 0;

  tessera_ram_wbp_if b0 ();
  tessera_ram_wbp_if b1 ();
  tessera_ram_wbp_if b2 ();

  assign b0.wb_cyc_i = cyc && (tgt == 0);
  assign b1.wb_cyc_i = cyc && (tgt == 1);
  assign b2.wb_cyc_i = cyc && (tgt == 2);
  assign b0.wb_stb_i = stb;  assign b1.wb_stb_i = stb;  assign b2.wb_stb_i = stb;
  assign b0.wb_adr_i = adr;  assign b1.wb_adr_i = adr;  assign b2.wb_adr_i = adr;
  assign b0.wb_sel_i = sel;  assign b1.wb_sel_i = sel;  assign b2.wb_sel_i = sel;
  assign b0.wb_we_i  = we;   assign b1.wb_we_i  = we;   assign b2.wb_we_i  = we;
  assign b0.wb_dat_i = wdat; assign b1.wb_dat_i = wdat; assign b2.wb_dat_i = wdat;
  assign b0.wb_cab_i = cab;  assign b1.wb_cab_i = cab;  assign b2.wb_cab_i = cab;

  tessera_ram_wbp #(.ADDR_W(10), .BASE(32'h0000_0000), .WAIT(0), .BURST_EN(1'b1), .ERR_EN(1'b1))
    dut0 (.sys_wb_clk(clk), .sys_wb_res(rst), .wb(b0));
  tessera_ram_wbp #(.ADDR_W(10), .BASE(32'h0000_0000), .WAIT(3), .BURST_EN(1'b1), .ERR_EN(1'b0))
    dut1 (.sys_wb_clk(clk), .sys_wb_res(rst), .wb(b1));
  tessera_ram_wbp #(.ADDR_W(10), .BASE(32'h0000_2000), .WAIT(2), .BURST_EN(1'b1), .ERR_EN(1'b1))
    dut2 (.sys_wb_clk(clk), .sys_wb_res(rst), .wb(b2));

  logic        ack_s, err_s;
  logic [31:0] rdat_s;
  always_comb begin
    ack_s = b0.wb_ack_o; err_s = b0.wb_err_o; rdat_s = b0.wb_dat_o;
    if (tgt == 1) begin
      ack_s = b1.wb_ack_o; err_s = b1.wb_err_o; rdat_s = b1.wb_dat_o;
    end else if (tgt == 2) begin
      ack_s = b2.wb_ack_o; err_s = b2.wb_err_o; rdat_s = b2.wb_dat_o;
    end
  end

  // Reference model: one word array per instance plus its configuration.
  logic [31:0] mem_m [3][256];
  logic [31:0] base_m [3];
  int          wait_m [3];
  logic        erren_m [3];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lmask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  task automatic xfer(input int t, input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, output logic ga, output logic ge,
                      output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    tgt = t; adr = a; we = w; sel = s; wdat = d; cab = 1'b0; cyc = 1'b1; stb = 1'b1;
    lat = 0; ga = 1'b0; ge = 1'b0; rd = 32'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_s || err_s) begin
        ga = ack_s; ge = err_s; rd = rdat_s;
        break;
      end
      lat++;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic op(input int t, input logic [31:0] a, input logic w, input logic [3:0] s,
                    input logic [31:0] d, input string tag, output logic [31:0] rd);
    logic ga, ge, hit, exp_err;
    logic [7:0]  ix;
    logic [31:0] exp_d;
    int lat;
    xfer(t, a, w, s, d, ga, ge, rd, lat);
    hit     = (a[31:10] == base_m[t][31:10]);
    ix      = a[9:2];
    exp_err = !hit && erren_m[t];
    exp_d   = (hit && !w) ? (mem_m[t][ix] & lmask(s)) : 32'h0;
    chk({tag, ".ack"}, 32'(ga), 32'(!exp_err));
    chk({tag, ".err"}, 32'(ge), 32'(exp_err));
    chk({tag, ".lat"}, lat, hit ? wait_m[t] + 1 : 1);
    chk({tag, ".dat"}, rd, exp_d);
    if (hit && w) mem_m[t][ix] = (mem_m[t][ix] & ~lmask(s)) | (d & lmask(s));
  endtask

  // Read burst on dut0; bad_beat (1..3) substitutes a wrong address for that beat.
  task automatic burst(input logic [31:0] start, input int bad_beat, input string tag);
    logic [31:0] a;
    logic        seen;
    a = start;
    @(posedge clk); #1;
    tgt = 0; we = 1'b0; sel = 4'hF; cab = 1'b1; adr = start; cyc = 1'b1; stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = ack_s;
    end
    chk({tag, ".b0ack"}, 32'(seen), 32'h1);
    chk({tag, ".b0dat"}, rdat_s, mem_m[0][a[9:2]]);
    for (int b = 1; b < 4; b++) begin
      @(posedge clk); #1;
      a[9:2] = a[9:2] + 8'd1;
      adr = (b == bad_beat) ? (a ^ 32'h40) : a;
      @(negedge clk);
      if (b == bad_beat) begin
        chk({tag, ".mis_noack"}, 32'(ack_s), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
          @(negedge clk);
          seen = ack_s;
        end
        chk({tag, ".mis_ack"}, 32'(seen), 32'h1);
        chk({tag, ".mis_dat"}, rdat_s, mem_m[0][adr[9:2]]);
        break;
      end else begin
        chk({tag, ".ack"}, 32'(ack_s), 32'h1);
        chk({tag, ".dat"}, rdat_s, mem_m[0][a[9:2]]);
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; cab = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic        seen;
    base_m  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_2000};
    wait_m  = '{0, 3, 2};
    erren_m = '{1'b1, 1'b0, 1'b1};

    // Reset held with a live request: nothing may answer.
    tgt = 0; adr = 32'h10; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.ack", 32'(b0.wb_ack_o), 32'h0);
    chk("rst.err", 32'(b0.wb_err_o), 32'h0);
    chk("rst.dat", b0.wb_dat_o, 32'h0);
    chk("rst.ack2", 32'(b2.wb_ack_o), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 256; i++)
        op(t, base_m[t] + 32'(i * 4), 1'b1, 4'hF, $urandom, "pre", rd);

    op(0, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, "w0_wr", rd);
    op(0, 32'h10, 1'b0, 4'hF, 32'h0, "w0_rd", rd);
    chk("w0_rd.lit", rd, 32'hDEAD_BEEF);
    op(0, 32'h10, 1'b1, 4'b0101, 32'h1122_3344, "lane_wr", rd);
    op(0, 32'h10, 1'b0, 4'hF, 32'h0, "lane_rd", rd);
    chk("lane_rd.lit", rd, 32'hDE22_BE44);
    op(0, 32'h10, 1'b0, 4'b1000, 32'h0, "lane_rd8", rd);
    chk("lane_rd8.lit", rd, 32'hDE00_0000);
    op(0, 32'h10, 1'b1, 4'b0000, 32'hFFFF_FFFF, "sel0_wr", rd);
    op(0, 32'h10, 1'b0, 4'hF, 32'h0, "sel0_rd", rd);
    chk("sel0_rd.lit", rd, 32'hDE22_BE44);

    op(1, 32'h20, 1'b0, 4'hF, 32'h0, "w3_rd", rd);

    // dut1 (WAIT=3): strobe withdrawn while waiting, write must not land.
    @(posedge clk); #1;
    tgt = 1; adr = 32'h24; we = 1'b1; sel = 4'hF; wdat = 32'hBAD0_BAD0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | ack_s | err_s;
    end
    chk("drop.noack", 32'(seen), 32'h0);
    cyc = 1'b0;
    op(1, 32'h24, 1'b0, 4'hF, 32'h0, "drop.after", rd);

    burst(32'h0000_03F8, 0, "bwrap");
    burst(32'h0000_0100, 2, "bmis");

    op(0, 32'h0000_1000, 1'b1, 4'hF, 32'hCAFE_F00D, "oow_err", rd);
    op(0, 32'h0000_0000, 1'b0, 4'hF, 32'h0, "oow_keep", rd);
    op(1, 32'h0000_1000, 1'b0, 4'hF, 32'h0, "oow_ack", rd);
    chk("oow_ack.lit", rd, 32'h0);

    // dut2 (WAIT=2): reset lands while the write is being acked.
    @(posedge clk); #1;
    tgt = 2; adr = 32'h0000_2040; we = 1'b1; sel = 4'hF; wdat = 32'h5555_AAAA; cyc = 1'b1; stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = ack_s;
    end
    chk("rstw.ack_before", 32'(seen), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rstw.ack_drop", 32'(ack_s), 32'h0);
    chk("rstw.err_drop", 32'(err_s), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    op(2, 32'h0000_2040, 1'b0, 4'hF, 32'h0, "rstw.keep", rd);

    for (int t = 0; t < 3; t++) begin
      for (int n = 0; n < 100; n++) begin
        a = base_m[t] + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a ^ 32'h0000_1000;
        op(t, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, "rnd", rd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
